// File: rtl/ws2812_pkg.sv
// rtl/ws2812_pkg.sv - state type, default WS2812 timing and byte scaling helper
package ws2812_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        BIT,
        LATCH
    } state_t;

    localparam int T0H    = 4;
    localparam int T1H    = 9;
    localparam int TBIT   = 15;
    localparam int TRESET = 600;

    // (b * (br + 1)) >> 8 : br = 0xFF leaves the byte unchanged
    function automatic logic [7:0] scale_byte(input logic [7:0] b, input logic [7:0] br);
        return 8'(({8'd0, b} * ({8'd0, br} + 16'd1)) >> 8);
    endfunction

endpackage

// File: rtl/ws2812_bit.sv
// rtl/ws2812_bit.sv - one WS2812 bit cell: high for T1H/T0H cycles, low for the rest of TBIT
module ws2812_bit #(
    parameter int T0H   = ws2812_pkg::T0H,
    parameter int T1H   = ws2812_pkg::T1H,
    parameter int TBIT  = ws2812_pkg::TBIT,
    parameter int CNT_W = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic go,
    input  logic bit_val,
    output logic dout,
    output logic last
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] high_len;
    logic             active;
    logic             bit_q;

    assign cnt_inc  = cnt + CNT_W'(1);
    assign high_len = bit_q ? CNT_W'(T1H) : CNT_W'(T0H);
    assign last     = active && (cnt == CNT_W'(TBIT - 1));

    // go wins over last so back-to-back bits restart with no idle cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            active <= 1'b0;
            bit_q  <= 1'b0;
            dout   <= 1'b0;
        end else if (go) begin
            cnt    <= '0;
            active <= 1'b1;
            bit_q  <= bit_val;
            dout   <= 1'b1;
        end else if (last) begin
            active <= 1'b0;
            dout   <= 1'b0;
        end else if (active) begin
            cnt  <= cnt_inc;
            dout <= (cnt_inc < high_len);
        end
    end

endmodule

// File: rtl/ws2812_tx.sv
// rtl/ws2812_tx.sv - WS2812 frame transmitter; define WS2812_TX_BRIGHTNESS_EN for brightness scaling
module ws2812_tx #(
    parameter int addr_size = 8,
    parameter int T0H       = ws2812_pkg::T0H,
    parameter int T1H       = ws2812_pkg::T1H,
    parameter int TBIT      = ws2812_pkg::TBIT,
    parameter int TRESET    = ws2812_pkg::TRESET
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [addr_size-1:0] length,
    output logic [addr_size-1:0] rd_addr,
    input  logic [7:0]           rd_data,
    output logic                 dout,
    output logic                 busy,
    output logic                 done
`ifdef WS2812_TX_BRIGHTNESS_EN
    ,
    input  logic [7:0]           brightness
`endif
);

    import ws2812_pkg::*;

    localparam int MAX_A = (T0H > T1H) ? T0H : T1H;
    localparam int MAX_B = (TBIT > TRESET) ? TBIT : TRESET;
    localparam int CNT_W = $clog2((MAX_A > MAX_B) ? MAX_A : MAX_B);

    state_t               state, state_n;
    logic [addr_size-1:0] len_q;
    logic [7:0]           shift;
    logic [7:0]           load_byte;
    logic [2:0]           bit_idx;
    logic                 last_byte;
    logic                 load_wait;
    logic                 go_first;
    logic                 go;
    logic                 bit_last;
    logic                 more;
    logic                 latch_end;
    logic [CNT_W-1:0]     latch_cnt;

`ifdef WS2812_TX_BRIGHTNESS_EN
    logic [7:0] bright_q;
    assign load_byte = scale_byte(rd_data, bright_q);
`else
    assign load_byte = rd_data;
`endif

    // bit_idx has wrapped back to 7 once bit 0 of the final byte is on the wire
    assign more      = !(last_byte && (bit_idx == 3'd7));
    assign go        = go_first || (bit_last && more);
    assign latch_end = (latch_cnt == CNT_W'(TRESET - 1));

    ws2812_bit #(
        .T0H   (T0H),
        .T1H   (T1H),
        .TBIT  (TBIT),
        .CNT_W (CNT_W)
    ) u_bit (
        .clk     (clk),
        .reset   (reset),
        .go      (go),
        .bit_val (shift[7]),
        .dout    (dout),
        .last    (bit_last)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = (&length) ? LATCH : LOAD;
            LOAD:    if (load_wait) state_n = BIT;
            BIT:     if (bit_last && !more) state_n = LATCH;
            LATCH:   if (latch_end) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rd_addr   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            len_q     <= '0;
            shift     <= '0;
            bit_idx   <= 3'd7;
            last_byte <= 1'b0;
            load_wait <= 1'b0;
            go_first  <= 1'b0;
            latch_cnt <= '0;
`ifdef WS2812_TX_BRIGHTNESS_EN
            bright_q  <= '0;
`endif
        end else begin
            state    <= state_n;
            done     <= 1'b0;
            go_first <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q     <= length;
                        rd_addr   <= '0;
                        busy      <= 1'b1;
                        bit_idx   <= 3'd7;
                        last_byte <= 1'b0;
                        load_wait <= 1'b0;
                        latch_cnt <= '0;
`ifdef WS2812_TX_BRIGHTNESS_EN
                        bright_q  <= brightness;
`endif
                    end
                end
                LOAD: begin
                    load_wait <= 1'b1;
                    if (load_wait) begin
                        shift    <= load_byte;
                        go_first <= 1'b1;
                    end
                end
                BIT: begin
                    if (go) begin
                        bit_idx <= bit_idx - 3'd1;
                        // prefetch while the MSB goes out; the next byte is needed 7 bits later
                        if (bit_idx == 3'd7) begin
                            if (rd_addr == len_q) last_byte <= 1'b1;
                            else                  rd_addr   <= rd_addr + addr_size'(1);
                        end
                        shift <= (bit_idx == 3'd0) ? load_byte : {shift[6:0], 1'b0};
                    end
                end
                LATCH: begin
                    latch_cnt <= latch_cnt + CNT_W'(1);
                    if (latch_end) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_tx.sv
// tb/tb_ws2812_tx.sv - self-checking bench for ws2812_tx
module tb_ws2812_tx;

    localparam int T0H    = 4;
    localparam int T1H    = 9;
    localparam int TBIT   = 15;
    localparam int TRESET = 600;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] length;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       dout;
    logic       busy;
    logic       done;
`ifdef WS2812_TX_BRIGHTNESS_EN
    logic [7:0] brightness;
`endif

    logic [7:0] mem [0:255];
    int n_cmp  = 0;
    int n_fail = 0;
    bit exp_bits[$];
    int exp_addr[$];

    typedef struct {
        logic [7:0] len;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] d2;
        logic [7:0] br;
        int         inject_at;
    } vec_t;
    vec_t vecs[8];

    ws2812_tx #(
        .addr_size (8),
        .T0H       (T0H),
        .T1H       (T1H),
        .TBIT      (TBIT),
        .TRESET    (TRESET)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .length  (length),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .dout    (dout),
        .busy    (busy),
        .done    (done)
`ifdef WS2812_TX_BRIGHTNESS_EN
        ,
        .brightness (brightness)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= mem[rd_addr];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] expect_byte(input logic [7:0] b, input logic [7:0] br);
`ifdef WS2812_TX_BRIGHTNESS_EN
        int p;
        p = int'(b) * (int'(br) + 1);
        return 8'(p >> 8);
`else
        return b;
`endif
    endfunction

    task automatic run_frame(input string tag, input logic [7:0] len, input logic [7:0] d0,
                             input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] br,
                             input int inject_at, input int abort_rise);
        int nbytes, edges, first_rise, rises, h, last_h, low_run, nbit, done_seen, done_cnt;
        bit prev, e, aborted;
        logic [7:0] bv;
        int obs_addr[$];

        mem[0] = d0;
        mem[1] = d1;
        mem[2] = d2;
        nbytes = (len == 8'hFF) ? 0 : int'(len) + 1;
        exp_bits.delete();
        exp_addr.delete();
        for (int b = 0; b < nbytes; b++) begin
            bv = expect_byte(mem[b], br);
            for (int i = 7; i >= 0; i--) exp_bits.push_back(bv[i]);
            exp_addr.push_back(b);
        end

        @(negedge clk);
        start  = 1'b1;
        length = len;
`ifdef WS2812_TX_BRIGHTNESS_EN
        brightness = br;
`endif
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_after_start"}, busy, 1);
        obs_addr.delete();
        obs_addr.push_back(int'(rd_addr));

        edges = 0; first_rise = -1; rises = 0; h = 0; last_h = 0; low_run = 0;
        nbit = 0; done_seen = 0; prev = 1'b0; aborted = 1'b0;
        while (edges < 3000) begin
            @(negedge clk);
            edges++;
            if (inject_at != 0 && edges == inject_at) begin
                start  = 1'b1;
                length = 8'd5;
            end else if (inject_at != 0 && edges == inject_at + 1) begin
                start = 1'b0;
            end
            if (done) begin
                done_seen = 1;
                break;
            end
            if (busy && int'(rd_addr) != obs_addr[$]) obs_addr.push_back(int'(rd_addr));
            if (dout) begin
                if (!prev) begin
                    rises++;
                    if (first_rise < 0) first_rise = edges;
                    if (rises > 1) check($sformatf("%s_gap%0d", tag, rises), low_run, TBIT - last_h);
                    h = 0;
                end
                h++;
            end else begin
                if (prev) begin
                    last_h = h;
                    if (exp_bits.size() == 0) begin
                        check({tag, "_bit_count"}, nbit + 1, nbytes * 8);
                    end else begin
                        e = exp_bits.pop_front();
                        check($sformatf("%s_bit%0d_high", tag, nbit), h, e ? T1H : T0H);
                    end
                    nbit++;
                    low_run = 0;
                end
                low_run++;
            end
            prev = dout;
            if (abort_rise != 0 && dout && h == 1 && rises == abort_rise) begin
                reset   = 1'b1;
                aborted = 1'b1;
                break;
            end
        end

        if (aborted) begin
            @(negedge clk);
            reset = 1'b0;
            check({tag, "_dout_after_reset"}, dout, 0);
            check({tag, "_busy_after_reset"}, busy, 0);
            done_cnt = 0;
            repeat (TRESET + 50) begin
                @(negedge clk);
                if (done) done_cnt++;
            end
            check({tag, "_no_done"}, done_cnt, 0);
            return;
        end

        check({tag, "_done_seen"}, done_seen, 1);
        check({tag, "_done_edges"}, edges, (nbytes == 0) ? TRESET : 3 + TBIT * 8 * nbytes + TRESET);
        check({tag, "_first_rise"}, first_rise, (nbytes == 0) ? -1 : 3);
        check({tag, "_busy_at_done"}, busy, 0);
        check({tag, "_bits_left"}, exp_bits.size(), 0);
        if (nbytes != 0) begin
            check({tag, "_latch_low"}, low_run, (TBIT - last_h) + TRESET);
            check({tag, "_addr_count"}, obs_addr.size(), exp_addr.size());
            for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++)
                check($sformatf("%s_addr%0d", tag, i), obs_addr[i], exp_addr[i]);
        end
        @(negedge clk);
        check({tag, "_done_width"}, done, 0);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        reset  = 1'b1;
        start  = 1'b0;
        length = 8'h00;
`ifdef WS2812_TX_BRIGHTNESS_EN
        brightness = 8'hFF;
`endif
        repeat (3) @(negedge clk);
        check("reset_dout", dout, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_rd_addr", int'(rd_addr), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        vecs[0] = '{8'h00, 8'h80, 8'h00, 8'h00, 8'hFF, 0};
        vecs[1] = '{8'h02, 8'hFF, 8'h00, 8'hA5, 8'hFF, 0};
        vecs[2] = '{8'hFF, 8'h55, 8'h55, 8'h55, 8'hFF, 0};
        vecs[3] = '{8'h01, 8'h3C, 8'hC3, 8'h00, 8'hFF, 20};
        vecs[4] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 0};
        vecs[5] = '{8'h02, 8'h01, 8'h7E, 8'h80, 8'hFF, 0};
        vecs[6] = '{8'h00, 8'hFF, 8'h00, 8'h00, 8'h7F, 0};
        vecs[7] = '{8'h00, 8'hA5, 8'h00, 8'h00, 8'hFF, 0};

        for (int v = 0; v < 8; v++)
            run_frame($sformatf("v%0d", v), vecs[v].len, vecs[v].d0, vecs[v].d1, vecs[v].d2,
                      vecs[v].br, vecs[v].inject_at, 0);

        // abort during bit 5 of byte 1 (11th bit on the wire), then a clean single-byte frame
        run_frame("abort", 8'h01, 8'h5A, 8'hC3, 8'h00, 8'hFF, 0, 11);
        run_frame("after_abort", 8'h00, 8'h96, 8'h00, 8'h00, 8'hFF, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ws2812_tx.md
WS2812_TX -- requirements
Module: ws2812_tx

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
  addr_size  8    frame-buffer address width
  T0H        4    high cycles for a 0 bit
  T1H        9    high cycles for a 1 bit
  TBIT       15   total cycles per bit
  TRESET     600  low cycles of the end-of-frame latch
REQ-002 Ports (name, direction, width, meaning) SHALL be, in this order:
  clk      in   1          clock
  reset    in   1          reset, synchronous, active-high
  start    in   1          one-cycle frame-complete pulse
  length   in   addr_size  index of last byte; all-ones means empty frame
  rd_addr  out  addr_size  frame-buffer read address
  rd_data  in   8          buffer data, valid one cycle after rd_addr
  dout     out  1          WS2812 serial line
  busy     out  1          frame in progress
  done     out  1          one-cycle pulse when the latch ends

Function
REQ-003 State machine SHALL have the states IDLE, LOAD, BIT and LATCH.
REQ-004 In IDLE, when start=1: latch length, set rd_addr<=0 and busy<=1, then go to LOAD; if the latched length is all-ones, go to LATCH instead.
REQ-005 start SHALL be ignored while busy=1.
REQ-006 LOAD SHALL wait for rd_data, load it into an 8-bit shift register and enter BIT; dout SHALL first rise 3 cycles after start is sampled.
REQ-007 Bits SHALL be sent MSB first. Each bit SHALL be exactly TBIT cycles: dout high for T1H (bit=1) or T0H (bit=0), then low for the rest of the bit.
REQ-008 The next byte SHALL be prefetched (rd_addr incremented) during bit 7 of the current byte, so byte boundaries add zero extra cycles.
REQ-009 After the bit 0 of byte index length completes, the block SHALL enter LATCH with dout=0 for TRESET cycles.
REQ-010 At the end of LATCH the block SHALL pulse done=1 for one cycle, set busy=0 in that same cycle, and return to IDLE.
REQ-011 All outputs SHALL be registered. Counters SHALL be sized with $clog2 of the largest timing parameter.

Reset
REQ-012 On reset the block SHALL go to IDLE with dout=0, busy=0, done=0 and rd_addr=0, effective on the next clock edge.
REQ-013 A reset mid-frame SHALL abort the frame with no done pulse; the next start SHALL run normally.

Configuration
REQ-014 With WS2812_TX_BRIGHTNESS_EN defined:
  - an input port brightness[7:0] SHALL be added;
  - brightness SHALL be latched at start;
  - each byte SHALL be transmitted as (byte*(brightness+1))>>8, computed at load with no extra latency.
REQ-015 Without WS2812_TX_BRIGHTNESS_EN, the port and the scaling logic SHALL NOT exist, and bytes SHALL be transmitted unchanged.

Structure
REQ-016 Package ws2812_pkg SHALL hold the state enum typedef and the default timing constants (T0H, T1H, TBIT, TRESET).
REQ-017 Sub-module ws2812_bit SHALL generate the single-bit waveform: bit-value input, go pulse, cycle counter, dout, and last-cycle flag.

Verification
REQ-018 length=0, byte 0x80:
  - dout high 9 / low 6 for bit 7;
  - 7 bits of high 4 / low 11;
  - 600 cycles low;
  - done pulses once, busy falls.
REQ-019 length=2, bytes FF,00,A5:
  - 24 contiguous bits, 360 cycles from first rise to latch start;
  - rd_addr sequence 0,1,2;
  - no gap at byte boundaries.
REQ-020 length=all-ones: no high pulse, 600-cycle latch, then done.
REQ-021 A second start with length=5 asserted during BIT of a length=1 frame SHALL be ignored: exactly 16 bits are sent.
REQ-022 Reset asserted in bit 5 of byte 1: dout=0 and busy=0 next cycle, no done; a following start with length=0 SHALL send 8 bits correctly.
REQ-023 With WS2812_TX_BRIGHTNESS_EN: brightness=0x7F, byte 0xFF -> 0x7F transmitted; brightness=0xFF -> byte unchanged.
